shift_count_register: RTL and testbench

- Parametrised successor to the basic load/inc/clear register, used for the accumulator and data-path registers.
- Adds decrement and an extend flip-flop E (carry/borrow/link bit).
- Adds multi-cycle rotate-through-E, left or right, with a busy/done handshake.
- Provides a zero flag for the control unit's skip/branch decisions.

---
 rtl/shift_count_register_if.sv | 35 +++
 rtl/shift_count_register.sv | 109 ++++++++++
 tb/tb_shift_count_register.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/shift_count_register_if.sv
// Bus bundle for shift_count_register: command strobes, operands and register/status outputs.
// The master drives the strobes and operands; the slave is the register itself.
interface shift_count_register_if #(
  parameter int N   = 16,
  parameter int SHW = 5
);
  logic           load;
  logic           inc;
  logic           dec;
  logic           shl;
  logic           shr;
  logic           clear;
  logic [SHW-1:0] shamt;
  logic [N-1:0]   data;
  logic [N-1:0]   Q;
  logic           E;
  logic           zero;
  logic           busy;
  logic           done;
  logic           dbg_state;

  // Handshake: a strobe is accepted at a rising edge only while busy==0.
  // shl/shr with shamt=k>0 raises busy for exactly k cycles. Strobes seen
  // while busy==1 are dropped. done pulses for the one cycle after the last
  // rotate step, and a new command may be presented during that cycle.
  modport master (
    output load, inc, dec, shl, shr, clear, shamt, data,
    input  Q, E, zero, busy, done, dbg_state
  );

  modport slave (
    input  load, inc, dec, shl, shr, clear, shamt, data,
    output Q, E, zero, busy, done, dbg_state
  );
endinterface

// File: rtl/shift_count_register.sv
// Accumulator-style register: load/inc/dec/clear plus multi-cycle rotate through E.
// Optional macro SATURATE_EN makes inc/dec saturate instead of wrapping.
module shift_count_register #(
  parameter int N   = 16,
  parameter int SHW = 5
) (
  input  logic                    clk,
  input  logic                    reset_n,
  shift_count_register_if.slave   bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [N-1:0]   ONE_N   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [SHW-1:0] ONE_SHW = {{(SHW-1){1'b0}}, 1'b1};

  state_t         r_state;
  logic           r_dir_left;
  logic [SHW-1:0] r_count;
  logic [N-1:0]   r_q;
  logic           r_e;
  logic           r_busy;
  logic           r_done;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_dir_left <= 1'b0;
      r_count    <= '0;
      r_q        <= '0;
      r_e        <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.load) begin
            r_q <= bus.data;
          end else if (bus.inc) begin
`ifdef SATURATE_EN
            if (&r_q) begin
              r_e <= 1'b1;
            end else begin
              r_q <= r_q + ONE_N;
              r_e <= 1'b0;
            end
`else
            {r_e, r_q} <= {1'b0, r_q} + {1'b0, ONE_N};
`endif
          end else if (bus.dec) begin
`ifdef SATURATE_EN
            if (r_q == '0) begin
              r_e <= 1'b1;
            end else begin
              r_q <= r_q - ONE_N;
              r_e <= 1'b0;
            end
`else
            r_q <= r_q - ONE_N;
            r_e <= (r_q == '0);
`endif
          end else if (bus.shl || bus.shr) begin
            // A zero rotate count is a no-op: no busy, no done.
            if (bus.shamt != '0) begin
              r_dir_left <= bus.shl;
              r_count    <= bus.shamt;
              r_state    <= SHIFT;
              r_busy     <= 1'b1;
            end
          end else if (bus.clear) begin
            r_q <= '0;
            r_e <= 1'b0;
          end
        end

        SHIFT: begin
          if (r_dir_left) begin
            {r_e, r_q} <= {r_q, r_e};
          end else begin
            {r_e, r_q} <= {r_q[0], r_e, r_q[N-1:1]};
          end
          r_count <= r_count - ONE_SHW;
          if (r_count == ONE_SHW) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Q         = r_q;
  assign bus.E         = r_e;
  assign bus.zero      = (r_q == '0);
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_shift_count_register.sv
// Self-checking bench for shift_count_register: directed plan steps, then random
// commands compared against a ring-arithmetic reference model of {E,Q}.
module tb_shift_count_register;

  logic clk;
  logic reset_n;
  int   n_pass;
  int   n_total;

  logic [15:0] m_q;
  logic        m_e;

  shift_count_register_if #(.N(16), .SHW(5)) bus ();

  shift_count_register #(.N(16), .SHW(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".Q"}, {16'h0, bus.Q}, {16'h0, m_q});
    chk({tag, ".E"}, {31'h0, bus.E}, {31'h0, m_e});
    chk({tag, ".zero"}, {31'h0, bus.zero}, {31'h0, (m_q == 16'h0)});
  endtask

  task automatic drive(input logic l, i, d, sl, sr, c, input logic [15:0] dat, input logic [4:0] sh);
    bus.load  = l;
    bus.inc   = i;
    bus.dec   = d;
    bus.shl   = sl;
    bus.shr   = sr;
    bus.clear = c;
    bus.data  = dat;
    bus.shamt = sh;
  endtask

  // Rotate the 17-bit ring {E,Q}; a right rotate by r equals a left rotate by 17-r.
  task automatic model_rotate(input logic left, input int k);
    longint v;
    int     r;
    v = {m_e, m_q};
    r = k % 17;
    if (!left) r = (17 - r) % 17;
    v = ((v << r) | (v >> (17 - r))) & 64'h1FFFF;
    m_e = v[16];
    m_q = v[15:0];
  endtask

  task automatic issue(input logic l, i, d, sl, sr, c, input logic [15:0] dat, input logic [4:0] sh);
    int     tmp;
    bit     rot;
    int     n;
    rot = 1'b0;
    drive(l, i, d, sl, sr, c, dat, sh);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 16'h0, 5'd0);
    if (l) begin
      m_q = dat;
    end else if (i) begin
`ifdef SATURATE_EN
      if (m_q == 16'hFFFF) m_e = 1'b1;
      else begin m_q = m_q + 16'd1; m_e = 1'b0; end
`else
      tmp = int'(m_q) + 1;
      m_e = (tmp > 65535);
      m_q = tmp[15:0];
`endif
    end else if (d) begin
`ifdef SATURATE_EN
      if (m_q == 16'h0) m_e = 1'b1;
      else begin m_q = m_q - 16'd1; m_e = 1'b0; end
`else
      tmp = int'(m_q) - 1;
      m_e = (tmp < 0);
      m_q = tmp[15:0];
`endif
    end else if (sl || sr) begin
      rot = (sh != 5'd0);
    end else if (c) begin
      m_q = 16'h0;
      m_e = 1'b0;
    end
    chk_state("cmd");
    chk("cmd.done", {31'h0, bus.done}, 32'h0);
    chk("cmd.busy", {31'h0, bus.busy}, {31'h0, rot});
    if (rot) begin
      n = 0;
      while (bus.busy && n < 40) begin
        // Strobes presented while busy must be dropped.
        drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
              16'($urandom), 5'($urandom));
        cycle();
        n++;
      end
      drive(0, 0, 0, 0, 0, 0, 16'h0, 5'd0);
      chk("rot.busy_cycles", n, {27'h0, sh});
      model_rotate(sl, int'(sh));
      chk_state("rot");
      chk("rot.done", {31'h0, bus.done}, 32'h1);
    end
  endtask

  initial begin
    logic [5:0]  s;
    logic [15:0] dat;
    n_pass  = 0;
    n_total = 0;
    m_q     = 16'h0;
    m_e     = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 16'h0, 5'd0);
    reset_n = 1'b0;
    cycle();
    cycle();
    chk_state("reset");
    chk("reset.busy", {31'h0, bus.busy}, 32'h0);
    chk("reset.done", {31'h0, bus.done}, 32'h0);
    reset_n = 1'b1;

    issue(1, 0, 0, 0, 0, 0, 16'h1234, 5'd0);
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    m_q = 16'h0;
    m_e = 1'b0;
    chk_state("sync_reset");

    issue(1, 0, 0, 0, 0, 0, 16'hFFFF, 5'd0);
    issue(0, 1, 0, 0, 0, 0, 16'h0, 5'd0);
    issue(1, 0, 0, 0, 0, 0, 16'h0000, 5'd0);
    issue(0, 0, 1, 0, 0, 0, 16'h0, 5'd0);
    issue(0, 0, 1, 0, 0, 0, 16'h0, 5'd0);

    issue(1, 0, 0, 0, 0, 0, 16'h8001, 5'd0);
    issue(0, 0, 0, 1, 0, 0, 16'h0, 5'd1);
    issue(0, 0, 0, 0, 1, 0, 16'h0, 5'd2);

    issue(1, 0, 0, 0, 0, 0, 16'hFFFF, 5'd0);
    issue(0, 1, 0, 0, 0, 0, 16'h0, 5'd0);
    issue(1, 0, 0, 0, 0, 0, 16'hA5A5, 5'd0);
    issue(0, 0, 0, 1, 0, 0, 16'h0, 5'd17);

    issue(1, 1, 0, 0, 0, 1, 16'h0007, 5'd0);
    issue(0, 0, 0, 1, 0, 0, 16'h0, 5'd0);
    issue(0, 0, 0, 0, 1, 0, 16'h0, 5'd0);
    issue(0, 0, 0, 1, 1, 0, 16'h0, 5'd3);

    // Reset lands on the edge that would perform step 3 of an 8-step rotate.
    drive(0, 0, 0, 1, 0, 0, 16'h0, 5'd8);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 16'h0, 5'd0);
    chk("mid.busy_start", {31'h0, bus.busy}, 32'h1);
    cycle();
    cycle();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    m_q = 16'h0;
    m_e = 1'b0;
    chk_state("mid_reset");
    chk("mid_reset.busy", {31'h0, bus.busy}, 32'h0);
    chk("mid_reset.done", {31'h0, bus.done}, 32'h0);
    cycle();
    chk("mid_reset.done_after", {31'h0, bus.done}, 32'h0);
    chk("mid_reset.busy_after", {31'h0, bus.busy}, 32'h0);

    for (int t = 0; t < 150; t++) begin
      s = 6'($urandom_range(0, 63) & $urandom_range(0, 63));
      case ($urandom_range(0, 3))
        0:       dat = 16'hFFFF;
        1:       dat = 16'h0000;
        default: dat = 16'($urandom);
      endcase
      issue(s[0], s[1], s[2], s[3], s[4], s[5], dat, 5'($urandom_range(0, 20)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
